// File: rtl/spectral_peak_finder.sv
// Per-frame spectral peak extractor: scans bins 1..NFFT/2-1 once per frame and
// keeps the strongest above-threshold bin of each band, published atomically on commit.
module spectral_peak_finder #(
  parameter int NFFT      = 256,
  parameter int MAG_WIDTH = 32,
  parameter int NUM_BANDS = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         frame_valid,
  input  logic [MAG_WIDTH-1:0]         threshold,
  output logic [$clog2(NFFT)-1:0]      bin_addr,
  input  logic [MAG_WIDTH-1:0]         bin_mag,
  input  logic [$clog2(NUM_BANDS)-1:0] rd_band,
  output logic [$clog2(NFFT)-1:0]      rd_bin,
  output logic [MAG_WIDTH-1:0]         rd_mag,
  output logic                         rd_found,
  output logic                         done,
  output logic                         busy,
  output logic [31:0]                  frame_count,
  output logic                         overrun,
  input  logic                         overrun_clr
);

  localparam int ADDR_W     = $clog2(NFFT);
  localparam int BAND_W     = $clog2(NUM_BANDS);
  localparam int BAND_SIZE  = NFFT / (2 * NUM_BANDS);
  localparam int BAND_SHIFT = $clog2(BAND_SIZE);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NFFT / 2 - 1);

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, COMMIT} state_t;

  state_t              state, state_next;
  logic                frame_valid_q;
  logic                start;
  logic [ADDR_W-1:0]   addr_next;
  logic [ADDR_W-1:0]   bin_addr_q;
  logic                proc_en;
  logic                qualify;
  logic [BAND_W-1:0]   proc_band;

  logic [MAG_WIDTH-1:0] work_max   [NUM_BANDS];
  logic [ADDR_W-1:0]    work_bin   [NUM_BANDS];
  logic                 work_found [NUM_BANDS];
  logic [MAG_WIDTH-1:0] res_max    [NUM_BANDS];
  logic [ADDR_W-1:0]    res_bin    [NUM_BANDS];
  logic                 res_found  [NUM_BANDS];

  function automatic logic [BAND_W-1:0] band_of(input logic [ADDR_W-1:0] b);
    logic [ADDR_W-1:0] t;
    t = b >> BAND_SHIFT;
    return t[BAND_W-1:0];
  endfunction

  assign start = frame_valid & ~frame_valid_q;

  // bin_addr_q names the bin whose magnitude is on bin_mag this cycle; bin 0 (DC) is skipped.
  assign proc_en   = ((state == SCAN) || (state == FLUSH)) && (bin_addr_q != '0);
  assign proc_band = band_of(bin_addr_q);
  assign qualify   = proc_en && (bin_mag > threshold) && (bin_mag > work_max[proc_band]);

  always_comb begin
    state_next = state;
    addr_next  = bin_addr;
    done       = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy      = 1'b0;
        addr_next = '0;
        if (start) begin
          state_next = SCAN;
          addr_next  = ADDR_W'(1);
        end
      end
      SCAN: begin
        addr_next = bin_addr + 1'b1;
        if (bin_addr == LAST_ADDR) begin
          state_next = FLUSH;
          addr_next  = '0;
        end
      end
      FLUSH: begin
        addr_next  = '0;
        state_next = COMMIT;
      end
      COMMIT: begin
        done       = 1'b1;
        addr_next  = '0;
        state_next = IDLE;
      end
      default: begin
        addr_next  = '0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      bin_addr      <= '0;
      bin_addr_q    <= '0;
      frame_valid_q <= 1'b0;
      frame_count   <= '0;
      overrun       <= 1'b0;
    end else begin
      state         <= state_next;
      bin_addr      <= addr_next;
      bin_addr_q    <= bin_addr;
      frame_valid_q <= frame_valid;
      if (state == COMMIT)
        frame_count <= frame_count + 32'd1;
      // A new edge while busy wins over a simultaneous clear.
      if (start && busy)
        overrun <= 1'b1;
      else if (overrun_clr)
        overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_BANDS; i++) begin
        work_max[i]   <= '0;
        work_bin[i]   <= '0;
        work_found[i] <= 1'b0;
        res_max[i]    <= '0;
        res_bin[i]    <= '0;
        res_found[i]  <= 1'b0;
      end
    end else begin
      if ((state == IDLE) && start) begin
        for (int i = 0; i < NUM_BANDS; i++) begin
          work_max[i]   <= '0;
          work_bin[i]   <= '0;
          work_found[i] <= 1'b0;
        end
      end else if (qualify) begin
        work_max[proc_band]   <= bin_mag;
        work_bin[proc_band]   <= bin_addr_q;
        work_found[proc_band] <= 1'b1;
      end
      if (state == COMMIT) begin
        for (int i = 0; i < NUM_BANDS; i++) begin
          res_max[i]   <= work_max[i];
          res_bin[i]   <= work_bin[i];
          res_found[i] <= work_found[i];
        end
      end
    end
  end

  assign rd_bin   = res_bin[rd_band];
  assign rd_mag   = res_max[rd_band];
  assign rd_found = res_found[rd_band];

endmodule

// File: tb/tb_spectral_peak_finder.sv
// Bench for spectral_peak_finder: registered upstream spectrum mux plus a
// per-band "largest qualifying magnitude, lowest index" reference model.
module tb_spectral_peak_finder;

  localparam int NFFT      = 256;
  localparam int MAG_WIDTH = 32;
  localparam int NUM_BANDS = 8;
  localparam int HALF      = NFFT / 2;
  localparam int BAND_SIZE = HALF / NUM_BANDS;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 frame_valid = 1'b0;
  logic                 overrun_clr = 1'b0;
  logic [MAG_WIDTH-1:0] threshold = '0;
  logic [MAG_WIDTH-1:0] bin_mag = '0;
  logic [7:0]           bin_addr;
  logic [2:0]           rd_band = '0;
  logic [7:0]           rd_bin;
  logic [MAG_WIDTH-1:0] rd_mag;
  logic                 rd_found;
  logic                 done;
  logic                 busy;
  logic [31:0]          frame_count;
  logic                 overrun;

  logic [MAG_WIDTH-1:0] spec [NFFT];
  logic [7:0]           e_bin   [NUM_BANDS];
  logic [MAG_WIDTH-1:0] e_mag   [NUM_BANDS];
  logic                 e_found [NUM_BANDS];

  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    t0;
  int    td;
  logic [31:0] exp_fc = '0;

  spectral_peak_finder #(.NFFT(NFFT), .MAG_WIDTH(MAG_WIDTH), .NUM_BANDS(NUM_BANDS)) dut (
    .clk(clk), .reset(reset), .frame_valid(frame_valid), .threshold(threshold),
    .bin_addr(bin_addr), .bin_mag(bin_mag), .rd_band(rd_band), .rd_bin(rd_bin),
    .rd_mag(rd_mag), .rd_found(rd_found), .done(done), .busy(busy),
    .frame_count(frame_count), .overrun(overrun), .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Upstream SFFT output mux, registered once: one cycle of read latency.
  always @(posedge clk) bin_mag <= spec[bin_addr];

  task automatic clear_spec();
    for (int b = 0; b < NFFT; b++) spec[b] = '0;
  endtask

  // Reference: per band, the largest magnitude strictly above threshold among
  // bins 1..HALF-1, reported at the lowest bin index carrying that magnitude.
  task automatic model();
    for (int k = 0; k < NUM_BANDS; k++) begin
      logic [MAG_WIDTH-1:0] best;
      logic any;
      best = '0;
      any  = 1'b0;
      for (int b = k * BAND_SIZE; b < (k + 1) * BAND_SIZE; b++)
        if (b != 0 && spec[b] > threshold) begin
          any = 1'b1;
          if (spec[b] > best) best = spec[b];
        end
      e_found[k] = any;
      e_mag[k]   = best;
      e_bin[k]   = '0;
      if (any)
        for (int b = (k + 1) * BAND_SIZE - 1; b >= k * BAND_SIZE; b--)
          if (b != 0 && spec[b] == best) e_bin[k] = 8'(b);
    end
  endtask

  task automatic read_band(input int k);
    rd_band = 3'(k);
    #1;
  endtask

  // Produces a 0->1 edge on frame_valid; returns #1 after the edge T that samples it.
  task automatic begin_frame();
    @(negedge clk) frame_valid = 1'b0;
    @(negedge clk) frame_valid = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
  endtask

  task automatic wait_done(output int t);
    t = -1;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        t = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    tests++; if (bin_addr !== 8'd0) begin fails++; $display("FAIL reset bin_addr: got %0d want 0", bin_addr); end
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL reset busy/done: got %b/%b want 0/0", busy, done); end
    tests++; if (frame_count !== 32'd0) begin fails++; $display("FAIL reset frame_count: got %0d want 0", frame_count); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset overrun: got %b want 0", overrun); end
    for (int k = 0; k < NUM_BANDS; k++) begin
      read_band(k);
      tests++;
      if (rd_found !== 1'b0 || rd_bin !== 8'd0 || rd_mag !== '0) begin
        fails++;
        $display("FAIL reset band %0d: got found=%b bin=%0d mag=%0d want 0/0/0", k, rd_found, rd_bin, rd_mag);
      end
    end
  endtask

  task automatic test_impulse();
    clear_spec();
    spec[37] = 32'd1000;
    threshold = 32'd10;
    model();
    begin_frame();
    tests++; if (busy !== 1'b1 || bin_addr !== 8'd1) begin fails++; $display("FAIL impulse first cycle: got busy=%b bin_addr=%0d want 1/1", busy, bin_addr); end
    wait_done(td);
    tests++; if (td - t0 !== HALF) begin fails++; $display("FAIL impulse latency: got %0d want %0d", td - t0, HALF); end
    @(posedge clk); #1;
    exp_fc = exp_fc + 1;
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL impulse after done: got busy=%b done=%b want 0/0", busy, done); end
    tests++; if (frame_count !== exp_fc) begin fails++; $display("FAIL impulse frame_count: got %0d want %0d", frame_count, exp_fc); end
    read_band(2);
    tests++;
    if (rd_found !== 1'b1 || rd_bin !== 8'd37 || rd_mag !== 32'd1000) begin
      fails++;
      $display("FAIL impulse band 2: got found=%b bin=%0d mag=%0d want 1/37/1000", rd_found, rd_bin, rd_mag);
    end
    for (int k = 0; k < NUM_BANDS; k++) begin
      read_band(k);
      tests++;
      if (rd_found !== e_found[k] || rd_bin !== e_bin[k] || rd_mag !== e_mag[k]) begin
        fails++;
        $display("FAIL impulse band %0d: got %b/%0d/%0d want %b/%0d/%0d", k, rd_found, rd_bin, rd_mag, e_found[k], e_bin[k], e_mag[k]);
      end
    end
    frame_valid = 1'b0;
  endtask

  task automatic test_tie_threshold();
    clear_spec();
    spec[0]  = 32'd9999;
    spec[20] = 32'd500;
    spec[25] = 32'd500;
    spec[40] = 32'd10;
    threshold = 32'd10;
    model();
    begin_frame();
    wait_done(td);
    tests++; if (td - t0 !== HALF) begin fails++; $display("FAIL tie latency: got %0d want %0d", td - t0, HALF); end
    @(posedge clk); #1;
    exp_fc = exp_fc + 1;
    read_band(1);
    tests++; if (rd_found !== 1'b1 || rd_bin !== 8'd20 || rd_mag !== 32'd500) begin fails++; $display("FAIL tie band 1: got %b/%0d/%0d want 1/20/500", rd_found, rd_bin, rd_mag); end
    read_band(2);
    tests++; if (rd_found !== 1'b0) begin fails++; $display("FAIL threshold band 2: got found=%b want 0", rd_found); end
    read_band(0);
    tests++; if (rd_found !== 1'b0) begin fails++; $display("FAIL dc band 0: got found=%b want 0", rd_found); end
    tests++; if (frame_count !== exp_fc) begin fails++; $display("FAIL tie frame_count: got %0d want %0d", frame_count, exp_fc); end
    frame_valid = 1'b0;
  endtask

  task automatic test_ramp();
    for (int b = 0; b < NFFT; b++) spec[b] = 32'(b);
    threshold = '0;
    model();
    begin_frame();
    wait_done(td);
    @(posedge clk); #1;
    exp_fc = exp_fc + 1;
    for (int k = 0; k < NUM_BANDS; k++) begin
      read_band(k);
      tests++;
      if (rd_found !== 1'b1 || rd_bin !== 8'(16 * k + 15) || rd_mag !== 32'(16 * k + 15)) begin
        fails++;
        $display("FAIL ramp band %0d: got %b/%0d/%0d want 1/%0d/%0d", k, rd_found, rd_bin, rd_mag, 16 * k + 15, 16 * k + 15);
      end
    end
    frame_valid = 1'b0;
  endtask

  task automatic test_random();
    for (int f = 0; f < 3; f++) begin
      for (int b = 0; b < NFFT; b++) spec[b] = 32'($urandom_range(0, 40));
      threshold = 32'($urandom_range(0, 30));
      model();
      begin_frame();
      wait_done(td);
      tests++; if (td - t0 !== HALF) begin fails++; $display("FAIL random%0d latency: got %0d want %0d", f, td - t0, HALF); end
      @(posedge clk); #1;
      exp_fc = exp_fc + 1;
      tests++; if (frame_count !== exp_fc || overrun !== 1'b0) begin fails++; $display("FAIL random%0d count/overrun: got %0d/%b want %0d/0", f, frame_count, overrun, exp_fc); end
      for (int k = 0; k < NUM_BANDS; k++) begin
        read_band(k);
        tests++;
        if (rd_found !== e_found[k] || rd_bin !== e_bin[k] || rd_mag !== e_mag[k]) begin
          fails++;
          $display("FAIL random%0d band %0d: got %b/%0d/%0d want %b/%0d/%0d", f, k, rd_found, rd_bin, rd_mag, e_found[k], e_bin[k], e_mag[k]);
        end
      end
      frame_valid = 1'b0;
    end
  endtask

  task automatic test_overrun();
    clear_spec();
    spec[100] = 32'd77;
    spec[3]   = 32'd5;
    threshold = 32'd1;
    model();
    begin_frame();
    repeat (25) @(posedge clk);
    @(negedge clk) frame_valid = 1'b0;
    while (cyc < t0 + 50) @(posedge clk);
    @(negedge clk) frame_valid = 1'b1;
    wait_done(td);
    tests++; if (td - t0 !== HALF) begin fails++; $display("FAIL overrun latency: got %0d want %0d", td - t0, HALF); end
    @(posedge clk); #1;
    exp_fc = exp_fc + 1;
    tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL overrun flag: got %b want 1", overrun); end
    tests++; if (frame_count !== exp_fc) begin fails++; $display("FAIL overrun frame_count: got %0d want %0d", frame_count, exp_fc); end
    for (int k = 0; k < NUM_BANDS; k++) begin
      read_band(k);
      tests++;
      if (rd_found !== e_found[k] || rd_bin !== e_bin[k] || rd_mag !== e_mag[k]) begin
        fails++;
        $display("FAIL overrun band %0d: got %b/%0d/%0d want %b/%0d/%0d", k, rd_found, rd_bin, rd_mag, e_found[k], e_bin[k], e_mag[k]);
      end
    end
    repeat (5) @(posedge clk);
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL overrun restart: got busy=%b want 0", busy); end
    @(negedge clk) overrun_clr = 1'b1;
    @(negedge clk) overrun_clr = 1'b0;
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL overrun clear: got %b want 0", overrun); end
    frame_valid = 1'b0;
  endtask

  task automatic test_atomic_reset();
    logic seen_done;
    // Result bank still holds the overrun frame's results.
    for (int b = 0; b < NFFT; b++) spec[b] = 32'($urandom_range(100, 5000));
    begin_frame();
    while (cyc < t0 + 30) @(posedge clk);
    #1;
    read_band(2);
    tests++;
    if (rd_found !== e_found[2] || rd_bin !== e_bin[2] || rd_mag !== e_mag[2]) begin
      fails++;
      $display("FAIL atomic band 2: got %b/%0d/%0d want %b/%0d/%0d", rd_found, rd_bin, rd_mag, e_found[2], e_bin[2], e_mag[2]);
    end
    while (cyc < t0 + 60) @(posedge clk);
    #3 reset = 1'b0;
    frame_valid = 1'b0;
    #1;
    exp_fc = '0;
    tests++;
    if (bin_addr !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || frame_count !== 32'd0 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL midscan reset: got addr=%0d busy=%b done=%b fc=%0d ovr=%b want all 0", bin_addr, busy, done, frame_count, overrun);
    end
    for (int k = 0; k < NUM_BANDS; k++) begin
      read_band(k);
      tests++;
      if (rd_found !== 1'b0 || rd_bin !== 8'd0 || rd_mag !== '0) begin
        fails++;
        $display("FAIL midscan reset band %0d: got %b/%0d/%0d want 0/0/0", k, rd_found, rd_bin, rd_mag);
      end
    end
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    seen_done = 1'b0;
    repeat (140) begin
      @(posedge clk); #1;
      if (done || busy) seen_done = 1'b1;
    end
    tests++; if (seen_done !== 1'b0 || frame_count !== 32'd0) begin fails++; $display("FAIL abort no commit: got activity=%b fc=%0d want 0/0", seen_done, frame_count); end
  endtask

  task automatic test_wrap();
    clear_spec();
    spec[64] = 32'd123;
    threshold = '0;
    @(negedge clk) force dut.frame_count = 32'hFFFF_FFFF;
    @(negedge clk) release dut.frame_count;
    #1;
    tests++; if (frame_count !== 32'hFFFF_FFFF) begin fails++; $display("FAIL wrap preset: got %h want ffffffff", frame_count); end
    begin_frame();
    wait_done(td);
    tests++; if (td - t0 !== HALF) begin fails++; $display("FAIL wrap done: got latency %0d want %0d", td - t0, HALF); end
    @(posedge clk); #1;
    tests++; if (frame_count !== 32'd0) begin fails++; $display("FAIL wrap frame_count: got %0d want 0", frame_count); end
    read_band(4);
    tests++; if (rd_found !== 1'b1 || rd_bin !== 8'd64 || rd_mag !== 32'd123) begin fails++; $display("FAIL wrap band 4: got %b/%0d/%0d want 1/64/123", rd_found, rd_bin, rd_mag); end
    frame_valid = 1'b0;
  endtask

  initial begin
    clear_spec();
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_impulse();
    test_tie_threshold();
    test_ramp();
    test_random();
    test_overrun();
    test_atomic_reset();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spectral_peak_finder.md
# spectral_peak_finder

Frame-level peak extractor that sits directly downstream of the SFFT pipeline. On each new spectrum frame it walks the positive-frequency bins once and records, for each of NUM_BANDS equal-width bands, the strongest bin above a programmable threshold. The results are published atomically to a result bank, which the bus read-mapping logic can read out one band at a time, with a frame counter alongside.

## Interface
- NFFT, 256, FFT length; a power of two ≥ 2·NUM_BANDS; only bins 0..NFFT/2−1 are scanned
- MAG_WIDTH, 32, bin magnitude width (unsigned)
- NUM_BANDS, 8, band count; a power of two dividing NFFT/2; BAND_SIZE = NFFT/(2·NUM_BANDS)

Ports:
- clk  in  1  system clock; the single clock domain
- reset  in  1  asynchronous, active-low reset
- frame_valid  in  1  upstream OutputValid level; each 0→1 edge marks a new frame
- threshold  in  MAG_WIDTH  minimum magnitude; a bin must be strictly greater to qualify
- bin_addr  out  log2(NFFT)  bin index driven to the parent's SFFT_Out mux
- bin_mag  in  MAG_WIDTH  magnitude of the bin addressed in the previous cycle
- rd_band  in  log2(NUM_BANDS)  result-bank read select (combinational read)
- rd_bin  out  log2(NFFT)  peak bin index for rd_band
- rd_mag  out  MAG_WIDTH  peak magnitude for rd_band
- rd_found  out  1  band had a qualifying bin in the last committed frame
- done  out  1  one-cycle pulse on commit
- busy  out  1  high in SCAN, FLUSH and COMMIT
- frame_count  out  32  committed-frame counter
- overrun  out  1  sticky; a frame edge arrived while busy
- overrun_clr  in  1  clears overrun

## Operation
- State machine states: IDLE, SCAN, FLUSH, COMMIT.
- Frame edge detection: frame_valid is registered once; start = frame_valid & ~frame_valid_q.
- IDLE:
  - bin_addr = 0.
  - On start: clear the working bank (max=0, bin=0, found=0 for every band), set bin_addr=1, go to SCAN.
- SCAN:
  - Each cycle the block processes the bin_mag for the address issued in the previous cycle, then increments bin_addr.
  - After address NFFT/2−1 is issued, go to FLUSH.
- FLUSH: process the final bin_mag; bin_addr returns to 0; go to COMMIT.
- COMMIT:
  - Copy the working bank to the result bank in one cycle.
  - frame_count += 1, wrapping from 2^32−1 to 0.
  - done=1; go to IDLE.
- Bin 0 (DC) is never processed. Band 0 covers bins 1..BAND_SIZE−1; band k covers bins k·BAND_SIZE..(k+1)·BAND_SIZE−1.
- Update rule for bin b, band k = b / BAND_SIZE: if bin_mag > threshold and bin_mag > work_max[k], store max=bin_mag, bin=b, found=1.
  - Comparisons are strict, so on a tie the lower bin index is kept.
- The result bank changes only in COMMIT; reads during a scan return the previous frame's results.
- A start while busy is ignored (it does not restart the scan), and overrun is set.
  - If a set and overrun_clr occur in the same cycle, the set wins.
- threshold is sampled every cycle; it must be held stable during a scan.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert in the parent):
  - state=IDLE, bin_addr=0, done=0, busy=0, frame_count=0, overrun=0.
  - Result and working banks cleared, so rd_bin=0, rd_mag=0, rd_found=0.
  - frame_valid_q=0, so a frame_valid held high across reset deassertion produces a start on the first clock.
- Assertion mid-scan aborts immediately. No partial commit occurs, and frame_count is not incremented.
- Start sampled at clock edge T:
  - busy=1 from T.
  - bin_addr=1 during cycle T; addresses 1..NFFT/2−1 occupy cycles T..T+NFFT/2−2.
  - FLUSH at T+NFFT/2−1; COMMIT (done=1) at T+NFFT/2.
- Start-to-done latency: NFFT/2 cycles (128 for NFFT=256). busy falls the cycle after done.
- The upstream mux must be combinational from bin_addr and the bin_mag path registered once, giving exactly 1-cycle read latency.
- A start in the same cycle as COMMIT counts as an overrun. A start in the first IDLE cycle after COMMIT is accepted.
- rd_* outputs follow rd_band combinationally and reflect a commit starting the cycle after done.

## Test plan
- Reset, then a single impulse: NFFT=256, bin 37 = 1000, all other bins 0, threshold=10 → done at start+128; band 2: bin 37, mag 1000, found=1; all other bands found=0; frame_count=1.
- Tie and threshold checks:
  - Band 1 bins 20 and 25 both = 500 → rd_bin=20.
  - Bin 40 = 10 with threshold=10 → band 2 found=0.
  - DC bin 0 = 9999 → band 0 found=0.
- Ramp, bin b = b for all b, threshold=0 → band k reports bin 16k+15, mag 16k+15.
- Overrun: second frame_valid edge 50 cycles after the first → scan completes unchanged, overrun=1, frame_count=1. Then pulse overrun_clr → overrun=0.
- Atomicity and reset: read band 2 mid-scan → previous frame's value. Assert reset at start+60 → all outputs 0, bin_addr=0, no done pulse.
- frame_count wrap: force the counter to 0xFFFFFFFF, run one frame → frame_count=0, done=1.
